// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single-ported memory, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed data-over-fetch priority otherwise.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iIReq,
  input  logic [ADDR_W-1:0] iIAddr,
  output logic              oIGnt,
  output logic              oIValid,
  output logic [DATA_W-1:0] oIRData,
  input  logic              iDReq,
  input  logic              iDWe,
  input  logic [ADDR_W-1:0] iDAddr,
  input  logic [DATA_W-1:0] iDWData,
  output logic              oDGnt,
  output logic              oDValid,
  output logic [DATA_W-1:0] oDRData,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWData,
  output logic              oMemWren,
  input  logic [DATA_W-1:0] iMemQ,
  output logic              oBusy
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state, stateNxt;
  logic [CNT_W-1:0]  cnt, cntNxt;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wDataQ;
  logic              weQ;
  logic              winD;
  logic              pickD;
  logic              anyReq;
  logic              capture;

  assign anyReq = iIReq | iDReq;

`ifdef ARB_ROUND_ROBIN_EN
  // Last-served pointer: 1 = data port served last; reset means fetch served last
  logic lastD;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      lastD <= 1'b0;
    end else if (state == IDLE && anyReq) begin
      lastD <= pickD;
    end
  end

  assign pickD = iDReq & (~iIReq | ~lastD);
`else
  assign pickD = iDReq;
`endif

  // State register and read-latency counter
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
    end
  end

  // Winner's transaction is latched on the sampling edge in IDLE
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      winD   <= 1'b0;
      weQ    <= 1'b0;
      addrQ  <= '0;
      wDataQ <= '0;
    end else if (state == IDLE && anyReq) begin
      winD   <= pickD;
      weQ    <= pickD & iDWe;
      addrQ  <= pickD ? iDAddr : iIAddr;
      wDataQ <= pickD ? iDWData : '0;
    end
  end

  // Read-data holding registers; only reads update them
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oIRData <= '0;
      oDRData <= '0;
    end else if (capture) begin
      if (winD) begin
        oDRData <= iMemQ;
      end else begin
        oIRData <= iMemQ;
      end
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    stateNxt  = state;
    cntNxt    = cnt;
    capture   = 1'b0;
    oIGnt     = 1'b0;
    oDGnt     = 1'b0;
    oIValid   = 1'b0;
    oDValid   = 1'b0;
    oMemAddr  = '0;
    oMemWData = '0;
    oMemWren  = 1'b0;
    oBusy     = (state != IDLE);
    case (state)
      IDLE: begin
        if (anyReq) begin
          stateNxt = ISSUE;
        end
      end
      ISSUE: begin
        oIGnt     = ~winD;
        oDGnt     = winD;
        oMemAddr  = addrQ;
        oMemWData = wDataQ;
        oMemWren  = weQ;
        if (weQ) begin
          stateNxt = DONE;
        end else begin
          stateNxt = WAIT;
          cntNxt   = CNT_W'(RD_LAT - 1);
        end
      end
      WAIT: begin
        oMemAddr = addrQ;
        if (cnt == '0) begin
          capture  = 1'b1;
          stateNxt = DONE;
        end else begin
          cntNxt = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        oIValid  = ~winD;
        oDValid  = winD;
        stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: an RD_LAT=1 instance with a scoreboard and an RD_LAT=3 instance.
module tb_mem_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic          isD;
    logic [DW-1:0] data;
  } sbItem_t;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  // Instance A (RD_LAT = 1)
  logic          aIReq, aIGnt, aIValid, aDReq, aDWe, aDGnt, aDValid, aMemWren, aBusy;
  logic [AW-1:0] aIAddr, aDAddr, aMemAddr;
  logic [DW-1:0] aIRData, aDWData, aDRData, aMemWData, aMemQ;

  // Instance B (RD_LAT = 3)
  logic          bIReq, bIGnt, bIValid, bDReq, bDWe, bDGnt, bDValid, bMemWren, bBusy;
  logic [AW-1:0] bIAddr, bDAddr, bMemAddr;
  logic [DW-1:0] bIRData, bDWData, bDRData, bMemWData, bMemQ;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
    .iCLK(clk), .iRST(rstN),
    .iIReq(aIReq), .iIAddr(aIAddr), .oIGnt(aIGnt), .oIValid(aIValid), .oIRData(aIRData),
    .iDReq(aDReq), .iDWe(aDWe), .iDAddr(aDAddr), .iDWData(aDWData),
    .oDGnt(aDGnt), .oDValid(aDValid), .oDRData(aDRData),
    .oMemAddr(aMemAddr), .oMemWData(aMemWData), .oMemWren(aMemWren), .iMemQ(aMemQ),
    .oBusy(aBusy)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
    .iCLK(clk), .iRST(rstN),
    .iIReq(bIReq), .iIAddr(bIAddr), .oIGnt(bIGnt), .oIValid(bIValid), .oIRData(bIRData),
    .iDReq(bDReq), .iDWe(bDWe), .iDAddr(bDAddr), .iDWData(bDWData),
    .oDGnt(bDGnt), .oDValid(bDValid), .oDRData(bDRData),
    .oMemAddr(bMemAddr), .oMemWData(bMemWData), .oMemWren(bMemWren), .iMemQ(bMemQ),
    .oBusy(bBusy)
  );

  // Memory for instance A: async read, sync write, plus a preload port
  logic [DW-1:0] memA [1024];
  logic          preEn;
  logic [AW-1:0] preAddr;
  logic [DW-1:0] preData;

  always @(posedge clk) begin
    if (aMemWren) memA[aMemAddr] <= aMemWData;
    else if (preEn) memA[preAddr] <= preData;
  end
  assign aMemQ = memA[aMemAddr];
  assign bMemQ = (bMemAddr == 10'h030) ? 32'h1234_5678 : 32'hBAD0_0000;

  int      checks = 0;
  int      errors = 0;
  int      wrenCycles = 0;
  sbItem_t sb [$];
  sbItem_t item;
  logic    found;
  logic [3:0] expD;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    preAddr = addr;
    preData = data;
    preEn   = 1'b1;
    @(posedge clk);
    #1 preEn = 1'b0;
  endtask

  task automatic waitValidA(input logic wantD, input string tag);
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (wantD ? aDValid : aIValid) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, 64'(found), 64'h1);
  endtask

  // Scoreboard monitor for instance A
  always @(negedge clk) begin
    if (rstN) begin
      if (aMemWren) wrenCycles++;
      if (aIValid || aDValid) begin
        chk("valid_onehot", 64'(aIValid & aDValid), 64'h0);
        chk("sb_underflow", 64'(sb.size() != 0), 64'h1);
        if (sb.size() != 0) begin
          item = sb.pop_front();
          chk("sb_port", 64'(aDValid), 64'(item.isD));
          chk("sb_data", 64'(aDValid ? aDRData : aIRData), 64'(item.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b0;
    preEn = 1'b0; preAddr = '0; preData = '0;
    aIReq = 0; aIAddr = '0; aDReq = 0; aDWe = 0; aDAddr = '0; aDWData = '0;
    bIReq = 0; bIAddr = '0; bDReq = 0; bDWe = 0; bDAddr = '0; bDWData = '0;
    preload(10'h010, 32'h0050_0093);
    cyc();
    chk("rst_busy", 64'(aBusy), 64'h0);
    chk("rst_gnt", 64'({aIGnt, aDGnt}), 64'h0);
    chk("rst_valid", 64'({aIValid, aDValid}), 64'h0);
    chk("rst_memaddr", 64'(aMemAddr), 64'h0);
    chk("rst_wren", 64'(aMemWren), 64'h0);
    chk("rst_rdata", 64'({aIRData, aDRData}), 64'h0);
    chk("rst_busy3", 64'(bBusy), 64'h0);
    rstN = 1'b1;

    // Lone fetch, RD_LAT=1
    cyc();
    aIReq = 1; aIAddr = 10'h010;
    sb.push_back({1'b0, 32'h0050_0093});
    cyc();
    chk("s1_gnt_c1", 64'(aIGnt), 64'h1);
    chk("s1_busy_c1", 64'(aBusy), 64'h1);
    chk("s1_addr_c1", 64'(aMemAddr), 64'h010);
    aIReq = 0;
    cyc();
    chk("s1_gnt_c2", 64'(aIGnt), 64'h0);
    chk("s1_busy_c2", 64'(aBusy), 64'h1);
    chk("s1_valid_c2", 64'(aIValid), 64'h0);
    cyc();
    chk("s1_valid_c3", 64'(aIValid), 64'h1);
    chk("s1_busy_c3", 64'(aBusy), 64'h1);
    chk("s1_rdata_c3", 64'(aIRData), 64'h0050_0093);
    cyc();
    chk("s1_busy_c4", 64'(aBusy), 64'h0);
    chk("s1_rdata_hold", 64'(aIRData), 64'h0050_0093);

    // Store then load of the same word
    wrenCycles = 0;
    aDReq = 1; aDWe = 1; aDAddr = 10'h020; aDWData = 32'hDEAD_BEEF;
    sb.push_back({1'b1, 32'h0});
    cyc();
    chk("s2_gnt", 64'(aDGnt), 64'h1);
    chk("s2_wren", 64'(aMemWren), 64'h1);
    chk("s2_addr", 64'(aMemAddr), 64'h020);
    chk("s2_wdata", 64'(aMemWData), 64'hDEAD_BEEF);
    aDReq = 0; aDWe = 0;
    cyc();
    chk("s2_dvalid", 64'(aDValid), 64'h1);
    chk("s2_wren_done", 64'(aMemWren), 64'h0);
    chk("s2_addr_done", 64'(aMemAddr), 64'h0);
    chk("s2_rdata_kept", 64'(aDRData), 64'h0);
    cyc();
    chk("s2_wren_count", 64'(wrenCycles), 64'h1);
    aDReq = 1; aDWe = 0; aDAddr = 10'h020;
    sb.push_back({1'b1, 32'hDEAD_BEEF});
    cyc();
    chk("s2_load_gnt", 64'(aDGnt), 64'h1);
    aDReq = 0;
    waitValidA(1'b1, "s2_load_timeout");
    chk("s2_load_data", 64'(aDRData), 64'hDEAD_BEEF);
    cyc();

    // Reset during a write in ISSUE: wren drops at once, no write, no valid
    aDReq = 1; aDWe = 1; aDAddr = 10'h040; aDWData = 32'h55;
    cyc();
    chk("rw_wren_issue", 64'(aMemWren), 64'h1);
    aDReq = 0; aDWe = 0;
    #2 rstN = 1'b0;
    #1;
    chk("rw_wren_async", 64'(aMemWren), 64'h0);
    chk("rw_busy_async", 64'(aBusy), 64'h0);
    chk("rw_gnt_async", 64'(aDGnt), 64'h0);
    chk("rw_addr_async", 64'(aMemAddr), 64'h0);
    chk("rw_rdata_async", 64'(aDRData), 64'h0);
    cyc();
    cyc();
    rstN = 1'b1;
    chk("rw_no_write", 64'(memA[10'h040] === 32'h55), 64'h0);

    // Contested requests held for four transactions
`ifdef ARB_ROUND_ROBIN_EN
    expD = 4'b0101;
`else
    expD = 4'b1111;
`endif
    aIReq = 1; aIAddr = 10'h010; aDReq = 1; aDWe = 0; aDAddr = 10'h020;
    for (int k = 0; k < 4; k++) begin
      sb.push_back({expD[k], expD[k] ? 32'hDEAD_BEEF : 32'h0050_0093});
    end
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
        cyc();
        if (aIGnt || aDGnt) begin
          found = 1'b1;
          break;
        end
      end
      chk($sformatf("s3_gnt_timeout%0d", k), 64'(found), 64'h1);
      chk($sformatf("s3_gnt_onehot%0d", k), 64'(aIGnt & aDGnt), 64'h0);
      chk($sformatf("s3_gnt_port%0d", k), 64'(aDGnt), 64'(expD[k]));
    end
    aIReq = 0; aDReq = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (sb.size() == 0 && !aBusy) break;
    end
    chk("s3_drain", 64'(sb.size()), 64'h0);

    // RD_LAT=3 fetch on instance B
    bIReq = 1; bIAddr = 10'h030;
    cyc();
    chk("s4_gnt_c1", 64'(bIGnt), 64'h1);
    chk("s4_addr_c1", 64'(bMemAddr), 64'h030);
    bIReq = 0;
    for (int c = 2; c <= 4; c++) begin
      cyc();
      chk($sformatf("s4_addr_c%0d", c), 64'(bMemAddr), 64'h030);
      chk($sformatf("s4_valid_c%0d", c), 64'(bIValid), 64'h0);
      chk($sformatf("s4_wren_c%0d", c), 64'(bMemWren), 64'h0);
    end
    cyc();
    chk("s4_valid_c5", 64'(bIValid), 64'h1);
    chk("s4_rdata_c5", 64'(bIRData), 64'h1234_5678);
    chk("s4_addr_c5", 64'(bMemAddr), 64'h0);
    cyc();
    chk("s4_idle", 64'(bBusy), 64'h0);

    // Reset pulse during WAIT on instance B with the fetch request still pending
    bIReq = 1; bIAddr = 10'h030;
    cyc();
    chk("s5_gnt", 64'(bIGnt), 64'h1);
    cyc();
    chk("s5_busy_wait", 64'(bBusy), 64'h1);
    #2 rstN = 1'b0;
    #1;
    chk("s5_busy_async", 64'(bBusy), 64'h0);
    chk("s5_addr_async", 64'(bMemAddr), 64'h0);
    chk("s5_rdata_async", 64'(bIRData), 64'h0);
    chk("s5_outs_async", 64'({bIGnt, bIValid, bMemWren}), 64'h0);
    cyc();
    cyc();
    rstN = 1'b1;
    cyc();
    chk("s5_gnt_after_rst", 64'(bIGnt), 64'h1);
    chk("s5_no_stale_valid", 64'(bIValid), 64'h0);
    bIReq = 0;
    for (int c = 2; c <= 4; c++) begin
      cyc();
      chk($sformatf("s5_novalid_c%0d", c), 64'(bIValid), 64'h0);
    end
    cyc();
    chk("s5_valid_new", 64'(bIValid), 64'h1);
    chk("s5_rdata_new", 64'(bIRData), 64'h1234_5678);
    cyc();
    chk("final_sb_empty", 64'(sb.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
